// File: rtl/execute_stage_if.sv
// Decode-side and memory-side buses of the execute stage.
// The master drives the in_* fields and receives the out_* fields; the slave is the stage itself.
interface execute_stage_if;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [4:0]  in_rd_addr;
  logic        in_rd_we;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_load_unsigned;
  logic [1:0]  in_width;

  logic        out_valid;
  logic [31:0] out_pc;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;
  logic [31:0] out_rd_wdata;
  logic        out_rd_forwardable;
  logic        out_is_load;
  logic        out_is_store;
  logic        out_load_unsigned;
  logic [1:0]  out_width;
  logic [31:0] out_mem_addr;
  logic [31:0] out_mem_wdata;

  modport master (
    output in_valid, in_pc, in_op, in_a, in_b, in_imm, in_use_imm, in_rd_addr,
           in_rd_we, in_is_load, in_is_store, in_load_unsigned, in_width,
    input  out_valid, out_pc, out_rd_addr, out_rd_we, out_rd_wdata, out_rd_forwardable,
           out_is_load, out_is_store, out_load_unsigned, out_width, out_mem_addr, out_mem_wdata
  );

  modport slave (
    input  in_valid, in_pc, in_op, in_a, in_b, in_imm, in_use_imm, in_rd_addr,
           in_rd_we, in_is_load, in_is_store, in_load_unsigned, in_width,
    output out_valid, out_pc, out_rd_addr, out_rd_we, out_rd_wdata, out_rd_forwardable,
           out_is_load, out_is_store, out_load_unsigned, out_width, out_mem_addr, out_mem_wdata
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: pipe register, single-cycle ALU and an optional radix-2 divider.
// Define MULDIV_DIVIDER_EN to build the divider; without it, ops 10-13 return 0.
module execute_stage (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  execute_stage_if.slave bus,
  output logic           stall_req
);
  logic        r_valid, r_use_imm, r_rd_we, r_is_load, r_is_store, r_load_unsigned;
  logic [31:0] r_pc, r_a, r_b, r_imm;
  logic [3:0]  r_op;
  logic [4:0]  r_rd_addr;
  logic [1:0]  r_width;
  logic        w_stall_req;
  logic [31:0] w_opb, w_mem_addr, w_alu;
  logic [4:0]  w_sh;

  // A divide in flight keeps its own operands, whatever the controller does with stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      r_valid <= 1'b0;  r_pc <= '0;  r_op <= '0;  r_a <= '0;  r_b <= '0;  r_imm <= '0;
      r_use_imm <= 1'b0;  r_rd_addr <= '0;  r_rd_we <= 1'b0;  r_is_load <= 1'b0;
      r_is_store <= 1'b0;  r_load_unsigned <= 1'b0;  r_width <= '0;
    end else if (!stall && !w_stall_req) begin
      r_valid <= bus.in_valid;  r_pc <= bus.in_pc;  r_op <= bus.in_op;  r_a <= bus.in_a;
      r_b <= bus.in_b;  r_imm <= bus.in_imm;  r_use_imm <= bus.in_use_imm;
      r_rd_addr <= bus.in_rd_addr;  r_rd_we <= bus.in_rd_we;  r_is_load <= bus.in_is_load;
      r_is_store <= bus.in_is_store;  r_load_unsigned <= bus.in_load_unsigned;
      r_width <= bus.in_width;
    end
  end

  assign w_opb      = r_use_imm ? r_imm : r_b;
  assign w_sh       = w_opb[4:0];
  assign w_mem_addr = r_a + r_imm;

`ifdef MULDIV_DIVIDER_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;
  div_state_t  r_state, w_state_nxt;
  logic [31:0] r_quot, r_rem, r_dvsr, w_a_abs, w_b_abs, w_div_res;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r;
  logic        w_signed, w_a_neg, w_b_neg, w_div0, w_ovf, w_start;
  logic [32:0] w_shift, w_diff;

  assign w_signed = !r_op[0];
  assign w_a_neg  = w_signed & r_a[31];
  assign w_b_neg  = w_signed & w_opb[31];
  assign w_a_abs  = w_a_neg ? -r_a : r_a;
  assign w_b_abs  = w_b_neg ? -w_opb : w_opb;
  assign w_div0   = (w_opb == '0);
  assign w_ovf    = w_signed && (r_a == 32'h8000_0000) && (w_opb == '1);
  assign w_start  = r_valid && (r_op >= 4'd10) && (r_op <= 4'd13);
  assign w_shift  = {r_rem, r_quot[31]};
  assign w_diff   = w_shift - {1'b0, r_dvsr};
  assign w_div_res = r_op[2] ? (r_neg_r ? -r_rem : r_rem) : (r_neg_q ? -r_quot : r_quot);
  assign w_stall_req = ((r_state == S_IDLE) && w_start) || (r_state == S_BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = (w_div0 || w_ovf) ? S_DONE : S_BUSY;
      S_BUSY:  if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      S_DONE:  if (!stall) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // Restoring division on magnitudes; signs are reapplied when the result is read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      r_quot <= '0;  r_rem <= '0;  r_dvsr <= '0;  r_cnt <= '0;  r_neg_q <= 1'b0;  r_neg_r <= 1'b0;
    end else if (r_state == S_IDLE && w_start) begin
      r_cnt <= '0;
      r_dvsr <= w_b_abs;
      if (w_div0) begin
        r_quot <= '1;  r_rem <= r_a;  r_neg_q <= 1'b0;  r_neg_r <= 1'b0;
      end else if (w_ovf) begin
        r_quot <= 32'h8000_0000;  r_rem <= '0;  r_neg_q <= 1'b0;  r_neg_r <= 1'b0;
      end else begin
        r_quot <= w_a_abs;  r_rem <= '0;  r_neg_q <= w_a_neg ^ w_b_neg;  r_neg_r <= w_a_neg;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 5'd1;
      if (!w_diff[32]) begin
        r_rem  <= w_diff[31:0];
        r_quot <= {r_quot[30:0], 1'b1};
      end else begin
        r_rem  <= w_shift[31:0];
        r_quot <= {r_quot[30:0], 1'b0};
      end
    end
  end
`else
  assign w_stall_req = 1'b0;
`endif

  always_comb begin
    w_alu = '0;
    case (r_op)
      4'd0:  w_alu = r_a + w_opb;
      4'd1:  w_alu = r_a - w_opb;
      4'd2:  w_alu = r_a << w_sh;
      4'd3:  w_alu = {31'b0, $signed(r_a) < $signed(w_opb)};
      4'd4:  w_alu = {31'b0, r_a < w_opb};
      4'd5:  w_alu = r_a ^ w_opb;
      4'd6:  w_alu = r_a >> w_sh;
      4'd7:  w_alu = $unsigned($signed(r_a) >>> w_sh);
      4'd8:  w_alu = r_a | w_opb;
      4'd9:  w_alu = r_a & w_opb;
`ifdef MULDIV_DIVIDER_EN
      4'd10, 4'd11, 4'd12, 4'd13: w_alu = w_div_res;
`endif
      default: w_alu = '0;
    endcase
  end

  assign stall_req              = w_stall_req;
  assign bus.out_valid          = r_valid && !w_stall_req;
  assign bus.out_pc             = r_pc;
  assign bus.out_rd_addr        = r_rd_addr;
  assign bus.out_rd_we          = r_valid && r_rd_we && !w_stall_req;
  assign bus.out_rd_wdata       = r_is_load ? w_mem_addr : w_alu;
  assign bus.out_is_load        = r_valid && r_is_load;
  assign bus.out_rd_forwardable = !(r_valid && r_is_load);
  assign bus.out_is_store       = r_valid && r_is_store && !w_stall_req;
  assign bus.out_load_unsigned  = r_load_unsigned;
  assign bus.out_width          = r_width;
  assign bus.out_mem_addr       = w_mem_addr;
  assign bus.out_mem_wdata      = r_b;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; divider checks follow MULDIV_DIVIDER_EN as the RTL does.
module tb_execute_stage;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, flush = 1'b0, stall_req;
  int   checks = 0, failures = 0, n;

  execute_stage_if bus ();
  execute_stage dut (.clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus), .stall_req(stall_req));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic use_imm, input logic ld, input logic st);
    bus.in_valid = v;  bus.in_pc = 32'h100;  bus.in_op = op;  bus.in_a = a;  bus.in_b = b;
    bus.in_imm = imm;  bus.in_use_imm = use_imm;  bus.in_rd_addr = 5'd5;  bus.in_rd_we = 1'b1;
    bus.in_is_load = ld;  bus.in_is_store = st;  bus.in_load_unsigned = 1'b0;  bus.in_width = 2'd2;
  endtask

`ifndef MULDIV_DIVIDER_EN
  logic r_seen_stall = 1'b0;
  always @(negedge clk) if (stall_req) r_seen_stall = 1'b1;
`endif

  initial begin
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_wdata", bus.out_rd_wdata, 0);
    chk("rst_fwd", bus.out_rd_forwardable, 1);
    chk("rst_stall_req", stall_req, 0);
    chk("rst_mem_addr", bus.out_mem_addr, 0);
    rst = 1'b1;

    drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h10, 1'b0, 1'b0, 1'b0);
    tick();
    chk("add_wdata", bus.out_rd_wdata, 32'h8000_0000);
    chk("add_valid", bus.out_valid, 1);
    chk("add_we", bus.out_rd_we, 1);
    chk("add_stall_req", stall_req, 0);
    chk("add_mem_addr", bus.out_mem_addr, 32'h8000_000F);
    chk("add_mem_wdata", bus.out_mem_wdata, 32'h1);
    chk("add_pc", bus.out_pc, 32'h100);

    drive(1'b1, 4'd1, 32'h5, 32'h7, '0, 1'b0, 1'b0, 1'b0);   tick(); chk("sub", bus.out_rd_wdata, 32'hFFFF_FFFE);
    drive(1'b1, 4'd7, 32'h8000_0000, 32'h0, 32'h24, 1'b1, 1'b0, 1'b0); tick(); chk("sra_imm", bus.out_rd_wdata, 32'hF800_0000);
    drive(1'b1, 4'd6, 32'h8000_0000, 32'h4, '0, 1'b0, 1'b0, 1'b0); tick(); chk("srl", bus.out_rd_wdata, 32'h0800_0000);
    drive(1'b1, 4'd2, 32'h3, 32'h21, '0, 1'b0, 1'b0, 1'b0);  tick(); chk("sll", bus.out_rd_wdata, 32'h6);
    drive(1'b1, 4'd3, 32'hFFFF_FFFF, 32'h1, '0, 1'b0, 1'b0, 1'b0); tick(); chk("slt", bus.out_rd_wdata, 32'h1);
    drive(1'b1, 4'd4, 32'hFFFF_FFFF, 32'h1, '0, 1'b0, 1'b0, 1'b0); tick(); chk("sltu", bus.out_rd_wdata, 32'h0);
    drive(1'b1, 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, '0, 1'b0, 1'b0, 1'b0); tick(); chk("xor", bus.out_rd_wdata, 32'h0FF0_0FF0);
    drive(1'b1, 4'd8, 32'hF000_0000, 32'h0000_000F, '0, 1'b0, 1'b0, 1'b0); tick(); chk("or", bus.out_rd_wdata, 32'hF000_000F);
    drive(1'b1, 4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, '0, 1'b0, 1'b0, 1'b0); tick(); chk("and", bus.out_rd_wdata, 32'hF000_F000);
    drive(1'b1, 4'd14, 32'h5, 32'h7, '0, 1'b0, 1'b0, 1'b0);  tick(); chk("op14", bus.out_rd_wdata, 32'h0);

    drive(1'b1, 4'd0, 32'h1000, 32'h55, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ld_mem_addr", bus.out_mem_addr, 32'h0000_0FFC);
    chk("ld_wdata", bus.out_rd_wdata, 32'h0000_0FFC);
    chk("ld_fwd", bus.out_rd_forwardable, 0);
    chk("ld_is_load", bus.out_is_load, 1);
    chk("ld_width", bus.out_width, 2);

    drive(1'b0, 4'd0, 32'h1, 32'h2, '0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("bub_valid", bus.out_valid, 0);
    chk("bub_we", bus.out_rd_we, 0);
    chk("bub_load", bus.out_is_load, 0);
    chk("bub_store", bus.out_is_store, 0);
    chk("bub_fwd", bus.out_rd_forwardable, 1);

    drive(1'b1, 4'd0, 32'h1, 32'h2, '0, 1'b0, 1'b0, 1'b1); tick();
    chk("store", bus.out_is_store, 1);
    stall = 1'b1;
    drive(1'b1, 4'd0, 32'd10, 32'd20, '0, 1'b0, 1'b0, 1'b0); tick();
    chk("stall_hold", bus.out_rd_wdata, 32'd3);
    stall = 1'b0; tick();
    chk("stall_release", bus.out_rd_wdata, 32'd30);
    flush = 1'b1; stall = 1'b1; tick(); flush = 1'b0; stall = 1'b0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_pc", bus.out_pc, 0);

`ifdef MULDIV_DIVIDER_EN
    drive(1'b1, 4'd10, 32'hFFFF_FFF9, 32'h2, '0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("div_busy_valid", bus.out_valid, 0);
    chk("div_busy_we", bus.out_rd_we, 0);
    n = 0;
    while (stall_req && n < 40) begin n++; tick(); end
    chk("div_stall_cycles", n, 33);
    chk("div_valid", bus.out_valid, 1);
    chk("div_wdata", bus.out_rd_wdata, 32'hFFFF_FFFD);
    tick();

    drive(1'b1, 4'd12, 32'hFFFF_FFF9, 32'h2, '0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (stall_req && n < 40) begin n++; tick(); end
    chk("rem_stall_cycles", n, 33);
    stall = 1'b1; tick(); tick();
    chk("rem_held_valid", bus.out_valid, 1);
    chk("rem_held_wdata", bus.out_rd_wdata, 32'hFFFF_FFFF);
    chk("rem_held_stall_req", stall_req, 0);
    stall = 1'b0; tick();
    chk("rem_released", bus.out_valid, 0);

    drive(1'b1, 4'd11, 32'd100, 32'd7, '0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (stall_req && n < 40) begin n++; tick(); end
    chk("divu_wdata", bus.out_rd_wdata, 32'd14);
    tick();

    drive(1'b1, 4'd11, 32'd5, 32'd0, '0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("div0_stall_req", stall_req, 1);
    tick();
    chk("div0_valid", bus.out_valid, 1);
    chk("div0_wdata", bus.out_rd_wdata, 32'hFFFF_FFFF);
    tick();

    drive(1'b1, 4'd13, 32'd5, 32'd0, '0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("remu0_wdata", bus.out_rd_wdata, 32'd5);
    tick();

    drive(1'b1, 4'd10, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ovf_valid", bus.out_valid, 1);
    chk("ovf_wdata", bus.out_rd_wdata, 32'h8000_0000);
    tick();

    drive(1'b1, 4'd10, 32'd100, 32'd3, '0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) tick();
    chk("pre_flush_stall_req", stall_req, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_div_stall_req", stall_req, 0);
    chk("flush_div_valid", bus.out_valid, 0);
    drive(1'b1, 4'd0, 32'd2, 32'd3, '0, 1'b0, 1'b0, 1'b0); tick();
    chk("post_flush_add", bus.out_rd_wdata, 32'd5);
    chk("post_flush_valid", bus.out_valid, 1);

    drive(1'b1, 4'd10, 32'd100, 32'd3, '0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    rst = 1'b0; #1;
    chk("rst_div_stall_req", stall_req, 0);
    chk("rst_div_valid", bus.out_valid, 0);
    #2 rst = 1'b1;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (bus.out_valid !== 1'b0 || stall_req !== 1'b0) break;
    end
    chk("rst_div_no_result", bus.out_valid, 0);
    chk("rst_div_idle", stall_req, 0);
`else
    drive(1'b1, 4'd10, 32'd100, 32'd3, '0, 1'b0, 1'b0, 1'b0); tick();
    chk("nodiv_stall_req", stall_req, 0);
    chk("nodiv_valid", bus.out_valid, 1);
    chk("nodiv_wdata", bus.out_rd_wdata, 0);
    drive(1'b1, 4'd13, 32'd100, 32'd0, '0, 1'b0, 1'b0, 1'b0); tick();
    chk("nodiv_remu", bus.out_rd_wdata, 0);
    drive(1'b1, 4'd0, 32'd2, 32'd3, '0, 1'b0, 1'b0, 1'b0); tick();
    chk("nodiv_next_add", bus.out_rd_wdata, 32'd5);
    chk("nodiv_never_stall", r_seen_stall, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have inputs stall and flush, 1 bit each, from the controller; stall freezes the pipe register, flush squashes it.
REQ-004 SHALL have decode-side inputs: in_valid 1, in_pc 32, in_op 4, in_a 32, in_b 32, in_imm 32, in_use_imm 1, in_rd_addr 5, in_rd_we 1, in_is_load 1, in_is_store 1, in_load_unsigned 1, in_width 2 (0 byte, 1 half, 2 word).
REQ-005 SHALL have memory-stage outputs: out_valid 1, out_pc 32, out_rd_addr 5, out_rd_we 1, out_rd_wdata 32, out_rd_forwardable 1, out_is_load 1, out_is_store 1, out_load_unsigned 1, out_width 2, out_mem_addr 32, out_mem_wdata 32.
REQ-006 SHALL have output stall_req, 1 bit, to the controller: high while a division occupies this stage.

Function
REQ-007 SHALL latch all in_* fields into a pipe register on each edge where stall=0 and flush=0; hold it when stall=1.
REQ-008 SHALL drive all out_* fields combinationally from the pipe register and divider state (no extra latency for ALU ops).
REQ-009 SHALL use operand B = in_use_imm ? imm : b, as latched.
REQ-010 SHALL implement in_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 DIV, 11 DIVU, 12 REM, 13 REMU; 14-15 yield 0; shifts use B[4:0]; all arithmetic modulo 2^32.
REQ-011 SHALL drive out_mem_addr = a + imm (mod 2^32) and out_mem_wdata = b, regardless of op.
REQ-012 SHALL drive out_rd_wdata = out_mem_addr when is_load=1 (memory stage decodes address from it), else the op result.
REQ-013 SHALL drive out_rd_forwardable = !is_load.
REQ-014 SHALL use a divider FSM, states IDLE, BUSY, DONE: IDLE->BUSY when a valid DIV/DIVU/REM/REMU sits in the pipe register; BUSY runs exactly 32 radix-2 iterations, then DONE; DONE->IDLE on the next non-stalled edge.
REQ-015 SHALL short-circuit IDLE->DONE (1-cycle) for divisor 0 (quotient 0xFFFFFFFF, remainder = dividend) and signed 0x80000000 / 0xFFFFFFFF (quotient 0x80000000, remainder 0).
REQ-016 SHALL follow RISC-V sign rules: signed quotient truncates toward zero, remainder takes dividend sign.
REQ-017 SHALL assert stall_req in IDLE (with a pending divide) and BUSY, deassert in DONE; total div latency 34 cycles normal, 2 cycles short-circuit.
REQ-018 SHALL force out_valid=0 and out_rd_we=0, out_is_store=0 while stall_req=1; result presented with out_valid=1 only in DONE.
REQ-019 SHALL, on flush=1, clear the pipe register to zero (bubble) and return the FSM to IDLE on that edge, aborting any division; flush wins over stall.
REQ-020 SHALL pass in_valid=0 entries as bubbles: out_valid=0, out_rd_we=0, out_is_load=0, out_is_store=0, no divide started.

Reset
REQ-021 SHALL, while rst=0, clear pipe register, divider registers and iteration counter to zero and FSM to IDLE, asynchronously.
REQ-022 SHALL present after reset: all out_* = 0, out_rd_forwardable = 1, stall_req = 0.
REQ-023 SHALL, on reset mid-division, discard the division; no result emitted.

Configuration
REQ-024 SHALL compile the divider in only when MULDIV_DIVIDER_EN is defined.
REQ-025 SHALL, without MULDIV_DIVIDER_EN, omit FSM and divider registers, treat ops 10-13 as result 0 in one cycle, and tie stall_req to 0.

Verification
REQ-026 SHALL cover: ADD a=0x7FFFFFFF, b=1 -> out_rd_wdata=0x80000000, out_valid=1 next cycle, stall_req=0.
REQ-027 SHALL cover: load a=0x1000, imm=0xFFFFFFFC, width=2 -> out_mem_addr=out_rd_wdata=0x00000FFC, out_rd_forwardable=0.
REQ-028 SHALL cover: DIV a=-7 (0xFFFFFFF9), b=2 -> stall_req high 33 cycles, then out_rd_wdata=0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-029 SHALL cover: DIVU a=5, b=0 -> 0xFFFFFFFF after 2 cycles; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-030 SHALL cover: flush at BUSY iteration 10 -> FSM IDLE, stall_req=0, out_valid=0 next cycle; following ADD correct.
REQ-031 SHALL cover: rst low during BUSY, stall=1 during DONE (result held until release), and MULDIV_DIVIDER_EN undefined -> DIV yields 0, stall_req never high.
